// File: rtl/ex3_bcd_seq.sv
// Sequences a packed word of excess-3 digits through one shared external converter, LSD first.
// Optional per-digit invalid-code checking is enabled by defining EX3_ERR_CHECK_EN.
module ex3_bcd_seq #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*DIGITS-1:0] in_data,
  output logic [3:0]          conv_in,
  input  logic [3:0]          conv_out,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] out_data,
  output logic [DIGITS-1:0]   err_mask,
  output logic                out_err
);

  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);
  localparam logic [3:0] EX3_ZERO = 4'b0011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [IW-1:0] idx;
  logic [W-1:0]  src;
  logic [3:0]    src_digit;
  logic          accept;
  logic          conv_active;
  logic          wr_err;
  logic [3:0]    wr_val;

  // Source digit currently selected by the index counter.
  assign src_digit = 4'(src >> {idx, 2'b00});

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake/converter drive.
  always_comb begin
    state_nxt   = state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    conv_in     = EX3_ZERO;
    accept      = 1'b0;
    conv_active = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = S_CONV;
        end
      end
      S_CONV: begin
        conv_in     = src_digit;
        conv_active = 1'b1;
        if (idx == LAST_IDX) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

`ifdef EX3_ERR_CHECK_EN
  // Legal excess-3 codes span 3..12; anything else is flagged and stored as F.
  assign wr_err = (src_digit < 4'h3) || (src_digit > 4'hC);
`else
  assign wr_err = 1'b0;
`endif

  assign wr_val = wr_err ? 4'hF : conv_out;

  // Source capture, index counter and result assembly.
  always_ff @(posedge clk) begin
    if (rst) begin
      src      <= '0;
      idx      <= '0;
      out_data <= '0;
    end else if (accept) begin
      src      <= in_data;
      idx      <= '0;
      out_data <= '0;
    end else if (conv_active) begin
      for (int unsigned i = 0; i < DIGITS; i++) begin
        if (idx == IW'(i)) begin
          out_data[4*i +: 4] <= wr_val;
        end
      end
      if (idx != LAST_IDX) begin
        idx <= idx + IW'(1);
      end
    end
  end

`ifdef EX3_ERR_CHECK_EN
  // Per-digit error flags; the summary flag is kept as its own flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_mask <= '0;
      out_err  <= 1'b0;
    end else if (accept) begin
      err_mask <= '0;
      out_err  <= 1'b0;
    end else if (conv_active && wr_err) begin
      for (int unsigned i = 0; i < DIGITS; i++) begin
        if (idx == IW'(i)) begin
          err_mask[i] <= 1'b1;
        end
      end
      out_err <= 1'b1;
    end
  end
`else
  assign err_mask = '0;
  assign out_err  = 1'b0;
`endif

endmodule

// File: tb/tb_ex3_bcd_seq.sv
// Directed self-checking bench for ex3_bcd_seq (DIGITS=4) with a behavioural excess-3 converter.
module tb_ex3_bcd_seq;

  localparam int unsigned DIGITS = 4;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [3:0]  conv_in;
  logic [3:0]  conv_out;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [3:0]  err_mask;
  logic        out_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  ex3_bcd_seq #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .conv_in   (conv_in),
    .conv_out  (conv_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .err_mask  (err_mask),
    .out_err   (out_err)
  );

  // Shared converter: excess-3 minus 3, wrapping (F maps to C).
  assign conv_out = conv_in - 4'd3;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    chk("in_ready_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic run_word(input logic [15:0] word, input logic [15:0] exp_data,
                          input logic [3:0] exp_mask);
    wait_ready();
    in_valid = 1'b1;
    in_data  = word;
    tick();
    in_valid = 1'b0;
    in_data  = ~word;
    chk("busy_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("conv_in_seq", 32'(conv_in), 32'(4'(word >> (4 * i))));
      chk("early_out_valid", 32'(out_valid), 32'd0);
      tick();
    end
    chk("out_valid", 32'(out_valid), 32'd1);
    chk("out_data", 32'(out_data), 32'(exp_data));
    chk("err_mask", 32'(err_mask), 32'(exp_mask));
    chk("out_err", 32'(out_err), 32'(|exp_mask));
    chk("done_conv_in", 32'(conv_in), 32'h3);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    chk("idle_out_valid", 32'(out_valid), 32'd0);
    chk("idle_hold_data", 32'(out_data), 32'(exp_data));
  endtask

  initial begin
    logic [15:0] res [2];
    int          acc_edge [2];
    int          nacc;
    int          nres;
    logic        a;
    logic        o;
    logic [15:0] od;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_err_mask", 32'(err_mask), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_conv_in", 32'(conv_in), 32'h3);

    run_word(16'h4567, 16'h1234, 4'b0000);
    run_word(16'h3333, 16'h0000, 4'b0000);
    run_word(16'hCCCC, 16'h9999, 4'b0000);
`ifdef EX3_ERR_CHECK_EN
    run_word(16'h3F33, 16'h0F00, 4'b0100);
`else
    run_word(16'h3F33, 16'h0C00, 4'b0000);
`endif

    // Backpressure in DONE with ignored input pulses.
    wait_ready();
    in_valid = 1'b1;
    in_data  = 16'h4567;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    for (int k = 0; k < 5; k++) begin
      in_valid = (k % 2 == 0);
      in_data  = 16'h3333;
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_out_data", 32'(out_data), 32'h1234);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    tick();
    chk("bp_no_stray_accept", 32'(in_ready), 32'd1);

    // Reset while idx==2.
    in_valid = 1'b1;
    in_data  = 16'h4567;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("mid_conv_in", 32'(conv_in), 32'h5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_in_ready", 32'(in_ready), 32'd1);
    chk("mrst_out_valid", 32'(out_valid), 32'd0);
    chk("mrst_out_data", 32'(out_data), 32'd0);
    chk("mrst_conv_in", 32'(conv_in), 32'h3);
    run_word(16'hCCCC, 16'h9999, 4'b0000);

    // Back-to-back words with in_valid held high.
    nacc      = 0;
    nres      = 0;
    acc_edge  = '{0, 0};
    res       = '{16'h0, 16'h0};
    in_valid  = 1'b1;
    in_data   = 16'h4567;
    out_ready = 1'b1;
    for (int n = 0; n < 40 && nres < 2; n++) begin
      a  = in_ready && in_valid;
      o  = out_valid;
      od = out_data;
      tick();
      if (a && nacc < 2) begin
        acc_edge[nacc] = cyc;
        nacc++;
        if (nacc == 1) in_data = 16'h9ABC;
        if (nacc == 2) in_valid = 1'b0;
      end
      if (o && nres < 2) begin
        res[nres] = od;
        nres++;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("b2b_accepts", 32'(nacc), 32'd2);
    chk("b2b_results", 32'(nres), 32'd2);
    chk("b2b_period", 32'(acc_edge[1] - acc_edge[0]), 32'(DIGITS + 2));
    chk("b2b_first", 32'(res[0]), 32'h1234);
    chk("b2b_second", 32'(res[1]), 32'h6789);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex3_bcd_seq.md
# ex3_bcd_seq

Multi-digit sequencer that time-shares one external combinational `Excess_3_BCD` converter across a packed word of excess-3 digits. It accepts one DIGITS-wide word over a valid/ready handshake and feeds the digits to the shared converter one per cycle, least-significant digit first. It collects the 4-bit BCD results and presents the assembled BCD word on a valid/ready output. It sits between the code-conversion datapath and any upstream producer of packed excess-3 data.

## Interface
- `DIGITS`, default 4: number of 4-bit digits per word; legal range 1..8.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  synchronous, active-high reset.
- `in_valid`  input  1  upstream word valid.
- `in_ready`  output  1  block can accept a word.
- `in_data`  input  4*DIGITS  packed excess-3 digits; digit i is `[4i+3:4i]`.
- `conv_in`  output  4  drives the shared converter's `in`.
- `conv_out`  input  4  converter's `out`; combinational, zero latency.
- `out_valid`  output  1  result word valid.
- `out_ready`  input  1  downstream accepts the result.
- `out_data`  output  4*DIGITS  packed BCD result.
- `err_mask`  output  DIGITS  per-digit invalid-code flags.
- `out_err`  output  1  OR of `err_mask`.

## Operation
- FSM states:
  - IDLE: `in_ready`=1.
    - On `in_valid`&&`in_ready`, latch `in_data` into the source register, clear the result register and `err_mask`, set idx=0, go to CONV.
  - CONV: `conv_in` = source digit[idx].
    - Each cycle, the block samples `conv_out` into result digit[idx] at the clock edge.
    - If idx==DIGITS-1, go to DONE. Otherwise idx increments.
  - DONE: `out_valid`=1.
    - On `out_ready`, go to IDLE.
- Outside CONV, `conv_in` = 4'b0011, the excess-3 code for zero.
- The index counter has width clog2(DIGITS), minimum 1 bit. It never wraps past DIGITS-1.
- `out_data`, `err_mask` and `out_err` are registered. They are stable throughout DONE and keep their last values in IDLE.
- The source register is captured only on the input handshake. Changes to `in_data` after acceptance are ignored.
- The block processes one word at a time. `in_ready` is low in CONV and DONE, so no input is accepted while a word is in flight.
- If `out_ready` is high in DONE and `in_valid` is high in the same cycle, the block does not accept the new word. It returns to IDLE and accepts that word on the following cycle.

## Timing
- Reset values:
  - state=IDLE, idx=0.
  - `in_ready`=1, `out_valid`=0.
  - `out_data`=0, `err_mask`=0, `out_err`=0, `conv_in`=4'b0011.
- Latency: accept at edge k. The block enters CONV at k, and `out_valid` rises after edge k+DIGITS.
- Minimum word period is DIGITS+2 cycles: CONV cycles, one DONE cycle, one IDLE cycle.
- `out_valid` holds with stable data until `out_ready`; it does not drop without a handshake.
- `rst` asserted in any state returns the block to reset values on the next edge. A word in flight is discarded with no `out_valid`.

## Configuration
- `EX3_ERR_CHECK_EN` defined:
  - Each source digit is checked against the valid excess-3 range 4'b0011..4'b1100.
  - For a digit outside the range, result digit[idx] is written as 4'hF instead of `conv_out`, and `err_mask[idx]` is set.
  - `out_err` = |`err_mask`.
- `EX3_ERR_CHECK_EN` undefined:
  - `conv_out` is stored unchanged for every digit.
  - `err_mask` and `out_err` are tied to 0.

## Test plan
- Normal conversion, DIGITS=4, `out_ready`=1: `in_data`=16'h4567 accepted → after 4 CONV cycles, `out_valid`=1, `out_data`=16'h1234, `out_err`=0. `conv_in` sequence is 7,6,5,4.
- Range endpoints: 16'h3333 → 16'h0000; 16'hCCCC → 16'h9999.
- Invalid digit, with `EX3_ERR_CHECK_EN`: 16'h3F33 → `out_data`=16'h0F00, `err_mask`=4'b0100, `out_err`=1.
- Same invalid-digit stimulus without the macro: `err_mask`=0, and `out_data` digit 2 equals the converter's output for 4'hF.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE → `out_valid` and `out_data` stable, `in_ready`=0, and `in_valid` pulses are ignored. Raising `out_ready` → IDLE next cycle.
- Reset mid-operation: assert `rst` when idx=2 → next cycle state=IDLE, `in_ready`=1, `out_valid`=0, `out_data`=0. A new word then converts correctly.
- Back-to-back: `in_valid` held high with two words (16'h4567, 16'h9ABC) → results 16'h1234 then 16'h6789. Second acceptance occurs exactly DIGITS+2 cycles after the first.
